// File: rtl/cybercobra_v2_if.sv
// Instruction-fetch bus between the CYBERCOBRA_V2 core (master) and instruction memory (slave).
interface cybercobra_v2_if #(
    parameter int IMEM_AW = 10
);
    logic               instr_req_o;
    logic [IMEM_AW-1:0] instr_addr_o;
    logic [31:0]        instr_i;
    logic               instr_valid_i;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_i,
        input  instr_valid_i
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_i,
        output instr_valid_i
    );
endinterface

// File: rtl/cybercobra_v2.sv
// CYBERCOBRA_V2 multi-cycle core: FETCH/EXEC/HALT FSM, register file, ALU, PC/branch logic.
// Optional macro CYBERCOBRA_V2_SW_SYNC_EN adds a two-flop synchroniser on sw_i.
module cybercobra_v2 #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int IMEM_AW    = 10,
    parameter int SW_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [SW_WIDTH-1:0]   sw_i,
    cybercobra_v2_if.master       imem,
    output logic [DATA_WIDTH-1:0] out_o,
    output logic                  halted_o
);
    localparam int RA_W = $clog2(REG_NUM);
    localparam int SH_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b01000,
        ALU_XOR  = 5'b00100,
        ALU_OR   = 5'b00110,
        ALU_AND  = 5'b00111,
        ALU_SLL  = 5'b00001,
        ALU_SRL  = 5'b00101,
        ALU_SRA  = 5'b01101,
        ALU_SLT  = 5'b00010,
        ALU_SLTU = 5'b00011,
        ALU_EQ   = 5'b11000,
        ALU_NE   = 5'b11001,
        ALU_LT   = 5'b11100,
        ALU_GE   = 5'b11101,
        ALU_LTU  = 5'b11110,
        ALU_GEU  = 5'b11111
    } alu_op_t;

    state_t               state;
    logic [IMEM_AW-1:0]   pc;
    logic [31:0]          ir;
    logic [DATA_WIDTH-1:0] rf [REG_NUM];

    logic                 f_j;
    logic                 f_b;
    logic [1:0]           f_ws;
    logic [4:0]           f_alu_op;
    logic [RA_W-1:0]      f_ra1;
    logic [RA_W-1:0]      f_ra2;
    logic [RA_W-1:0]      f_wa;
    logic [22:0]          f_const;
    logic [7:0]           f_offset;

    assign f_j      = ir[31];
    assign f_b      = ir[30];
    assign f_ws     = ir[29:28];
    assign f_alu_op = ir[27:23];
    assign f_ra1    = ir[18 +: RA_W];
    assign f_ra2    = ir[13 +: RA_W];
    assign f_wa     = ir[0 +: RA_W];
    assign f_const  = ir[27:5];
    assign f_offset = ir[12:5];

    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    assign rd1   = (f_ra1 == '0) ? '0 : rf[f_ra1];
    assign rd2   = (f_ra2 == '0) ? '0 : rf[f_ra2];
    assign out_o = rd1;

    // Width adaptation of CONST, switch data and branch offset
    logic [DATA_WIDTH-1:0] const_ext;
    logic [DATA_WIDTH-1:0] sw_ext;
    logic [IMEM_AW-1:0]    offset_ext;
    logic [SW_WIDTH-1:0]   sw_val;

    if (DATA_WIDTH > 23) begin : g_const_sext
        assign const_ext = {{(DATA_WIDTH-23){f_const[22]}}, f_const};
    end else begin : g_const_trunc
        assign const_ext = f_const[DATA_WIDTH-1:0];
    end

    if (DATA_WIDTH > SW_WIDTH) begin : g_sw_zext
        assign sw_ext = {{(DATA_WIDTH-SW_WIDTH){1'b0}}, sw_val};
    end else begin : g_sw_trunc
        assign sw_ext = sw_val[DATA_WIDTH-1:0];
    end

    if (IMEM_AW > 8) begin : g_off_sext
        assign offset_ext = {{(IMEM_AW-8){f_offset[7]}}, f_offset};
    end else begin : g_off_trunc
        // Truncating the offset is exact because the PC wraps modulo 2^IMEM_AW
        assign offset_ext = f_offset[IMEM_AW-1:0];
    end

`ifdef CYBERCOBRA_V2_SW_SYNC_EN
    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
        end
    end

    assign sw_val = sw_sync;
`else
    assign sw_val = sw_i;
`endif

    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_flag;
    logic [SH_W-1:0]       shamt;

    assign shamt = rd2[SH_W-1:0];

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (f_alu_op)
            ALU_ADD:  alu_res = rd1 + rd2;
            ALU_SUB:  alu_res = rd1 - rd2;
            ALU_XOR:  alu_res = rd1 ^ rd2;
            ALU_OR:   alu_res = rd1 | rd2;
            ALU_AND:  alu_res = rd1 & rd2;
            ALU_SLL:  alu_res = rd1 << shamt;
            ALU_SRL:  alu_res = rd1 >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(rd1) >>> shamt);
            ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(rd1) < $signed(rd2))};
            ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (rd1 < rd2)};
            ALU_EQ:   alu_flag = (rd1 == rd2);
            ALU_NE:   alu_flag = (rd1 != rd2);
            ALU_LT:   alu_flag = ($signed(rd1) < $signed(rd2));
            ALU_GE:   alu_flag = ($signed(rd1) >= $signed(rd2));
            ALU_LTU:  alu_flag = (rd1 < rd2);
            ALU_GEU:  alu_flag = (rd1 >= rd2);
            default: begin
                alu_res  = '0;
                alu_flag = 1'b0;
            end
        endcase
    end

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  halt_cond;
    logic                  take_offset;
    logic [IMEM_AW-1:0]    pc_next;

    always_comb begin
        wr_data = '0;
        case (f_ws)
            2'b00:   wr_data = const_ext;
            2'b01:   wr_data = alu_res;
            2'b10:   wr_data = sw_ext;
            default: wr_data = '0;
        endcase
    end

    assign wr_en       = !f_j && !f_b && (f_ws != 2'b11);
    assign halt_cond   = !f_j && !f_b && (f_ws == 2'b11);
    assign take_offset = f_j || (f_b && alu_flag);
    assign pc_next     = take_offset ? (pc + offset_ext) : (pc + 1'b1);

    assign imem.instr_req_o  = (state == FETCH) && !rst_i;
    assign imem.instr_addr_o = pc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= FETCH;
            pc       <= '0;
            ir       <= '0;
            halted_o <= 1'b0;
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem.instr_valid_i) begin
                        ir    <= imem.instr_i;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (halt_cond) begin
                        state    <= HALT;
                        halted_o <= 1'b1;
                    end else begin
                        if (wr_en && (f_wa != '0)) begin
                            rf[f_wa] <= wr_data;
                        end
                        pc    <= pc_next;
                        state <= FETCH;
                    end
                end
                HALT: begin
                    halted_o <= 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule
